// File: rtl/uart_rx_if.sv
// Byte-delivery side of the UART receiver: valid/ready handshake plus status pulses.
interface uart_rx_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              frame_err;
    logic              overrun;
    logic              busy;

    modport master (output data, valid, frame_err, overrun, busy, input ready);
    modport slave  (input data, valid, frame_err, overrun, busy, output ready);
endinterface

// File: rtl/uart_rx_deser.sv
// 8N1-style UART receiver: mid-bit sampling, one-entry holding register,
// framing-error and overrun pulses.
module uart_rx_deser #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    uart_rx_if.master  rx_if
);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t            state;
    logic [1:0]        sync;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              rx_s;

    assign rx_s = sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync            <= 2'b11;
            state           <= IDLE;
            cnt             <= '0;
            bit_idx         <= '0;
            shreg           <= '0;
            rx_if.data      <= '0;
            rx_if.valid     <= 1'b0;
            rx_if.frame_err <= 1'b0;
            rx_if.overrun   <= 1'b0;
            rx_if.busy      <= 1'b0;
        end else begin
            sync            <= {sync[0], uart_rx};
            rx_if.frame_err <= 1'b0;
            rx_if.overrun   <= 1'b0;
            // A load later in this block overrides the consume.
            if (rx_if.valid && rx_if.ready)
                rx_if.valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state      <= START;
                        cnt        <= '0;
                        rx_if.busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CW'(H - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state      <= IDLE;
                            rx_if.busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[DATA_W-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == BW'(DATA_W - 1))
                            state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                        cnt <= '0;
                        if (rx_s) begin
                            // Re-arm at mid-stop-bit so a back-to-back start edge is seen.
                            state      <= IDLE;
                            rx_if.busy <= 1'b0;
                            if (!rx_if.valid || rx_if.ready) begin
                                rx_if.data  <= shreg;
                                rx_if.valid <= 1'b1;
                            end else begin
                                rx_if.overrun <= 1'b1;
                            end
                        end else begin
                            rx_if.frame_err <= 1'b1;
                            state           <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    // Hold off until the line recovers so a break is flagged only once.
                    if (rx_s) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        rx_if.busy <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    rx_if.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: frame-level outcome model checked every cycle,
// plus directed checks of timing, glitch, framing, overrun and reset cases.
module tb_uart_rx_deser;
    localparam int CPB  = 16;
    localparam int DW   = 8;
    localparam int STOP_OFS = CPB / 2 + 2 + (DW + 1) * CPB;  // 154

    typedef struct {
        int         t0;
        int         edge_no;
        logic [7:0] d;
        logic       stop;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic line = 1'b1;
    logic abort = 1'b0;

    uart_rx_if #(.DATA_W(DW)) bus ();

    uart_rx_deser #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .uart_rx (line),
        .rx_if   (bus.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-outcome model: each frame sent is an event resolved at its stop-sample edge.
    ev_t        evq[$];
    int         ev_idx = 0;
    int         last_rst = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_ferr  = 1'b0;
    logic       m_ovr   = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid  <= 1'b0;
            m_data   <= 8'h00;
            m_ferr   <= 1'b0;
            m_ovr    <= 1'b0;
            last_rst <= cyc;
        end else begin
            m_ferr <= 1'b0;
            m_ovr  <= 1'b0;
            if (m_valid && bus.ready) m_valid <= 1'b0;
            if (ev_idx < evq.size() && evq[ev_idx].edge_no <= cyc + 1) begin
                ev_idx <= ev_idx + 1;
                if (evq[ev_idx].t0 > last_rst) begin
                    if (!evq[ev_idx].stop) m_ferr <= 1'b1;
                    else if (!m_valid || bus.ready) begin
                        m_valid <= 1'b1;
                        m_data  <= evq[ev_idx].d;
                    end else m_ovr <= 1'b1;
                end
            end
        end
    end

    // Monitor state, written only by the monitor thread.
    int         n_vcyc = 0, n_ferr = 0, n_ovr = 0, n_busy = 0;
    int         rise_edge = 0, ferr_edge = 0, ovr_edge = 0;
    logic [7:0] rise_data = 8'h00;
    logic       pv = 1'b0;

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("data", {24'h0, bus.data}, {24'h0, m_data});
                chk("valid", {31'h0, bus.valid}, {31'h0, m_valid});
                chk("frame_err", {31'h0, bus.frame_err}, {31'h0, m_ferr});
                chk("overrun", {31'h0, bus.overrun}, {31'h0, m_ovr});
            end
            if (bus.valid) n_vcyc++;
            if (bus.valid && !pv) begin
                rise_edge = cyc;
                rise_data = bus.data;
            end
            pv = bus.valid;
            if (bus.frame_err) begin n_ferr++; ferr_edge = cyc; end
            if (bus.overrun)   begin n_ovr++;  ovr_edge  = cyc; end
            if (bus.busy) n_busy++;
        end
    endtask

    // Caller must be at a negedge; line changes at negedges, edge 0 is the next posedge.
    task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
        logic [9:0] fr;
        ev_t ev;
        fr = {stop, b, 1'b0};
        t0 = cyc + 1;
        ev.t0 = t0; ev.edge_no = t0 + STOP_OFS; ev.d = b; ev.stop = stop;
        evq.push_back(ev);
        for (int i = 0; i < (DW + 2) * CPB; i++) begin
            line = abort ? 1'b1 : fr[i / CPB];
            @(negedge clk);
        end
        line = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"}, {24'h0, bus.data}, 32'h0);
        chk({tag, "_valid"}, {31'h0, bus.valid}, 32'h0);
        chk({tag, "_frame_err"}, {31'h0, bus.frame_err}, 32'h0);
        chk({tag, "_overrun"}, {31'h0, bus.overrun}, 32'h0);
        chk({tag, "_busy"}, {31'h0, bus.busy}, 32'h0);
    endtask

    initial begin
        int t0, t0b, sv, sf, so, sb;
        bus.ready = 1'b1;
        fork monitor(); join_none

        // Reset with idle line
        #1 chk_reset_outputs("rst_idle");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Good frame 0xA5, always ready
        sv = n_vcyc; sf = n_ferr; so = n_ovr;
        send_frame(8'hA5, 1'b1, t0);
        repeat (4) @(negedge clk);
        chk("a5_rise_edge", rise_edge - t0, 154);
        chk("a5_data", {24'h0, rise_data}, 32'hA5);
        chk("a5_valid_cycles", n_vcyc - sv, 1);
        chk("a5_no_ferr", n_ferr - sf, 0);
        chk("a5_no_ovr", n_ovr - so, 0);
        chk("a5_busy_after", {31'h0, bus.busy}, 32'h0);

        // Start-bit glitch: 4 low cycles
        sv = n_vcyc; sf = n_ferr; sb = n_busy;
        line = 1'b0;
        repeat (4) @(negedge clk);
        line = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_busy_window", {31'h0, (n_busy - sb >= 1) && (n_busy - sb <= CPB / 2 + 1)}, 1);
        chk("glitch_no_valid", n_vcyc - sv, 0);
        chk("glitch_no_ferr", n_ferr - sf, 0);
        send_frame(8'h5A, 1'b1, t0);
        repeat (4) @(negedge clk);
        chk("5a_data", {24'h0, rise_data}, 32'h5A);
        chk("5a_rise_edge", rise_edge - t0, 154);

        // Framing error: stop bit low, line held low 40 more cycles
        sv = n_vcyc; sf = n_ferr;
        send_frame(8'h3C, 1'b0, t0);
        line = 1'b0;
        repeat (40) @(negedge clk);
        chk("ferr_count", n_ferr - sf, 1);
        chk("ferr_edge", ferr_edge - t0, 154);
        chk("ferr_no_valid", n_vcyc - sv, 0);
        chk("ferr_busy_wait_idle", {31'h0, bus.busy}, 32'h1);
        line = 1'b1;
        repeat (6) @(negedge clk);
        chk("ferr_busy_released", {31'h0, bus.busy}, 32'h0);
        send_frame(8'hC3, 1'b1, t0);
        repeat (4) @(negedge clk);
        chk("c3_data", {24'h0, rise_data}, 32'hC3);

        // Overrun: not ready, back-to-back 0x11 / 0x22
        bus.ready = 1'b0;
        so = n_ovr;
        send_frame(8'h11, 1'b1, t0);
        send_frame(8'h22, 1'b1, t0b);
        repeat (4) @(negedge clk);
        chk("ovr_count", n_ovr - so, 1);
        chk("ovr_edge", ovr_edge - t0b, 154);
        chk("ovr_held_data", {24'h0, bus.data}, 32'h11);
        chk("ovr_held_valid", {31'h0, bus.valid}, 32'h1);
        bus.ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("ovr_drained_valid", {31'h0, bus.valid}, 32'h0);
        chk("ovr_drained_data", {24'h0, bus.data}, 32'h11);

        // Variant: ready pulsed exactly at the second stop-sample edge
        bus.ready = 1'b0;
        so = n_ovr;
        fork
            begin
                send_frame(8'h11, 1'b1, t0);
                send_frame(8'h22, 1'b1, t0b);
            end
            begin
                repeat (1 + CPB * (DW + 2) + STOP_OFS - 1) @(negedge clk);
                bus.ready = 1'b1;
                @(negedge clk);
                bus.ready = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        chk("swap_no_ovr", n_ovr - so, 0);
        chk("swap_data", {24'h0, bus.data}, 32'h22);
        chk("swap_valid", {31'h0, bus.valid}, 32'h1);
        bus.ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset during data bit 3 of 0xF0
        sv = n_vcyc;
        fork
            send_frame(8'hF0, 1'b1, t0);
            begin
                repeat (4 * CPB + CPB / 2) @(negedge clk);
                chk("rst_mid_busy_before", {31'h0, bus.busy}, 32'h1);
                #2 rst = 1'b1;
                abort = 1'b1;
                #1 chk_reset_outputs("rst_mid");
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        join
        abort = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_mid_no_delivery", n_vcyc - sv, 0);
        send_frame(8'h0F, 1'b1, t0);
        repeat (4) @(negedge clk);
        chk("0f_data", {24'h0, rise_data}, 32'h0F);
        chk("0f_rise_edge", rise_edge - t0, 154);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_deser.md
# uart_rx_deser

Serial-to-parallel UART receiver: the receive end of the team's 8N1 UART link, paired with the existing single-line transmitter. Recovers frames from the asynchronous serial line by mid-bit sampling with a programmable bit period. Delivers each byte through a valid/ready handshake with a one-entry holding register. Flags framing errors and overruns.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per serial bit; even, ≥ 4.
- DATA_W, default 8: data bits per frame; LSB first, no parity, one stop bit.

- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_uart_rx  in  1  serial line; idle high; asynchronous to i_clk.
- o_data  out  DATA_W  received byte; valid while o_valid = 1.
- o_valid  out  1  byte available in the holding register.
- i_ready  in  1  consumer accepts o_data when o_valid & i_ready at a clock edge.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- o_overrun  out  1  one-cycle pulse: good frame dropped because the holding register was full.
- o_busy  out  1  FSM is not in IDLE.

## Operation
- Synchronizer: two flops on i_uart_rx, both reset to 1; output rx_s. All FSM decisions use rx_s.
- Baud counter cnt: width clog2(CLKS_PER_BIT); cleared on every state change. Bit index: width clog2(DATA_W+1). H = CLKS_PER_BIT/2.
- FSM states and transitions:
  - IDLE: rx_s = 0 -> START.
  - START: cnt increments. At cnt == H-1, sample rx_s. If 0 -> DATA. If 1 -> IDLE (glitch, nothing reported).
  - DATA: at cnt == CLKS_PER_BIT-1, shift rx_s into the MSB of the shift register (right shift, LSB first) and increment the bit index. After DATA_W bits -> STOP.
  - STOP: at cnt == CLKS_PER_BIT-1, sample rx_s.
    - If 1: deliver the frame and go to IDLE at mid-stop-bit, so back-to-back frames are received.
    - If 0: pulse o_frame_err, discard the data, go to WAIT_IDLE.
  - WAIT_IDLE: rx_s = 1 -> IDLE. A break condition is reported once only.
- Delivery on a good stop bit:
  - Register empty (o_valid = 0), or being emptied the same edge (o_valid & i_ready): load o_data; o_valid <= 1.
  - Otherwise: pulse o_overrun. The held byte and o_valid are unchanged; the new byte is lost.
- Handshake: o_valid & i_ready with no simultaneous load -> o_valid <= 0. o_data keeps its last value.
  - o_valid must not drop without i_ready.
  - o_data must not change while o_valid = 1, except on a same-edge consume-and-load.
- Reset: all outputs 0, state IDLE, counters 0, synchronizer 1. Reset mid-frame abandons the frame with no error pulse.

## Timing
- Edge 0 = first rising edge at which i_uart_rx is low.
  - rx_s goes low after edge 1.
  - START is entered at edge 2.
  - Start bit sampled at edge H+2.
  - Data bit k sampled at edge H+2+(k+1)·CLKS_PER_BIT.
  - Stop bit sampled at edge H+2+(DATA_W+1)·CLKS_PER_BIT.
- o_valid, o_frame_err and o_overrun are registered. They change at the stop-sample edge; defaults give edge 154.
- o_busy is high from edge 2 through the stop-sample edge. It stays high through WAIT_IDLE.
- A pulse output is high for exactly one cycle.
- Frame period on the line: (DATA_W+2)·CLKS_PER_BIT. The FSM re-arms ½ bit before the frame ends.
- Jitter tolerance: any line edge within ±(H-1) cycles of nominal gives correct sampling.

## Test plan
All scenarios use defaults (CLKS_PER_BIT=16, DATA_W=8) and a TX model driving the line at 16 clocks/bit.
- Reset with the line idle -> o_data = 0x00; o_valid, o_frame_err, o_overrun, o_busy all 0. Assert i_rst asynchronously mid-cycle -> outputs clear before the next edge.
- Frame 0xA5 with i_ready = 1 -> o_valid high for exactly one cycle after edge 154, o_data = 0xA5, no error pulses, o_busy low afterwards.
- Line low for 4 cycles, then high -> no o_valid, no o_frame_err; o_busy high for at most H+1 cycles; a following 0x5A frame is received correctly.
- Frame 0x3C with stop bit 0, line held low for 40 more cycles -> one o_frame_err pulse at edge 154, no o_valid. FSM stays in WAIT_IDLE until the line goes high; a next 0xC3 frame is received.
- i_ready = 0, back-to-back 0x11 then 0x22 -> o_data holds 0x11, one o_overrun pulse at the second stop sample. Raising i_ready consumes 0x11; o_valid then stays 0 (0x22 lost). Variant: i_ready pulsed exactly at the second stop edge -> o_data = 0x22, no overrun.
- Assert i_rst during data bit 3 of 0xF0 -> all outputs return to their reset values and no partial byte is delivered. A subsequent 0x0F frame gives o_data = 0x0F.
